// File: rtl/gpio_expander_pkg.sv
// ----------------------------------------------------------------------------
// gpio_expander_pkg : frame layout, register map and reset values
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gpio_expander_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int PDATA_WIDTH = 8;
  localparam int PADDR_WIDTH = 3;

  localparam int RW_BIT   = 15;
  localparam int SEL_MSB  = 14;
  localparam int SEL_W    = 2;
  localparam int ADDR_MSB = 12;
  localparam int HDR_LSB  = 8;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_BANK0 = 2'b01;
  localparam sel_t SEL_BANK1 = 2'b10;

  localparam logic [PADDR_WIDTH-1:0] REG_OUT = 3'd0;
  localparam logic [PADDR_WIDTH-1:0] REG_DIR = 3'd1;
  localparam logic [PADDR_WIDTH-1:0] REG_IN  = 3'd2;

  localparam logic [PDATA_WIDTH-1:0] RST_OUT = 8'h00;
  localparam logic [PDATA_WIDTH-1:0] RST_DIR = 8'h00;

  // Returns the bank index addressed by a SEL code, or -1 when invalid.
  function automatic int sel_to_bank(input sel_t sel);
    case (sel)
      SEL_BANK0: return 0;
      SEL_BANK1: return 1;
      default:   return -1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_expander_bank.sv
// ----------------------------------------------------------------------------
// gpio_bank : OUT/DIR registers, IN read mux and tri-state driver for one bank
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gpio_bank
  import gpio_expander_pkg::*;
#(
  parameter int PDATA_WIDTH = gpio_expander_pkg::PDATA_WIDTH,
  parameter int PADDR_WIDTH = gpio_expander_pkg::PADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [PADDR_WIDTH-1:0] i_waddr,
  input  logic [PDATA_WIDTH-1:0] i_wdata,
  input  logic [PADDR_WIDTH-1:0] i_raddr,
  output logic [PDATA_WIDTH-1:0] o_rdata,
  inout  wire  [PDATA_WIDTH-1:0] io_pad
);

  logic [PDATA_WIDTH-1:0] r_out;
  logic [PDATA_WIDTH-1:0] r_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= RST_OUT;
      r_dir <= RST_DIR;
    end else if (i_we) begin
      case (i_waddr)
        REG_OUT: r_out <= i_wdata;
        REG_DIR: r_dir <= i_wdata;
        default: ;
      endcase
    end
  end

  // IN returns the resolved pin level, so externally driven values show up.
  always_comb begin
    o_rdata = '0;
    case (i_raddr)
      REG_OUT: o_rdata = r_out;
      REG_DIR: o_rdata = r_dir;
      REG_IN:  o_rdata = io_pad;
      default: o_rdata = '0;
    endcase
  end

  for (genvar i = 0; i < PDATA_WIDTH; i++) begin : g_pad
    assign io_pad[i] = r_dir[i] ? r_out[i] : 1'bz;
  end

endmodule

`default_nettype wire

// File: rtl/gpio_expander.sv
// ----------------------------------------------------------------------------
// gpio_expander : SPI mode-0 slave decoding 16-bit frames into banked GPIO
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gpio_expander
  import gpio_expander_pkg::*;
#(
  parameter int BANK_NUM    = 2,
  parameter int DATA_WIDTH  = gpio_expander_pkg::DATA_WIDTH,
  parameter int PDATA_WIDTH = gpio_expander_pkg::PDATA_WIDTH,
  parameter int ADDR_WIDTH  = 7,
  parameter int PADDR_WIDTH = gpio_expander_pkg::PADDR_WIDTH
) (
  input  logic                            sclk,
  input  logic                            resetn,
  input  logic                            ss,
  input  logic                            mosi,
  output wire                             miso,
  inout  wire  [BANK_NUM*PDATA_WIDTH-1:0] pad
);

  localparam logic [3:0] CNT_HDR_LAST = 4'd7;
  localparam logic [3:0] CNT_LAST     = 4'd15;

  logic [3:0]             r_cnt;
  logic [DATA_WIDTH-2:0]  r_shift;
  logic [PDATA_WIDTH-1:0] r_rdata;
  logic                   r_miso;

  // On the 8th edge r_shift holds frame bits 15:9; on the 16th it holds 15:1.
  logic                   w_rd_rw;
  sel_t                   w_rd_sel;
  logic [PADDR_WIDTH-1:0] w_rd_addr;
  logic                   w_wr_rw;
  sel_t                   w_wr_sel;
  logic [PADDR_WIDTH-1:0] w_wr_addr;
  logic [PDATA_WIDTH-1:0] w_wr_data;
  logic                   w_wr_go;
  logic [PDATA_WIDTH-1:0] w_bank_rdata [BANK_NUM];
  logic [PDATA_WIDTH-1:0] w_rd_mux;

  assign w_rd_rw   = r_shift[ADDR_WIDTH-1];
  assign w_rd_sel  = r_shift[SEL_MSB-HDR_LSB-1 -: SEL_W];
  assign w_rd_addr = r_shift[ADDR_MSB-HDR_LSB-1 -: PADDR_WIDTH];

  assign w_wr_rw   = r_shift[RW_BIT-1];
  assign w_wr_sel  = r_shift[SEL_MSB-1 -: SEL_W];
  assign w_wr_addr = r_shift[ADDR_MSB-1 -: PADDR_WIDTH];
  assign w_wr_data = {r_shift[PDATA_WIDTH-2:0], mosi};

  assign w_wr_go = ~ss & ~resetn & (r_cnt == CNT_LAST) & w_wr_rw;

  always_comb begin
    w_rd_mux = '0;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (sel_to_bank(w_rd_sel) == b) w_rd_mux = w_bank_rdata[b];
    end
  end

  // Deselect clears the frame state immediately, so a partial frame is lost.
  always_ff @(posedge sclk or posedge ss) begin
    if (ss) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_rdata <= '0;
    end else if (resetn) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt   <= r_cnt + 4'd1;
      r_shift <= {r_shift[DATA_WIDTH-3:0], mosi};
      if (r_cnt == CNT_HDR_LAST) r_rdata <= w_rd_rw ? '0 : w_rd_mux;
    end
  end

  always_ff @(negedge sclk or posedge ss) begin
    if (ss) begin
      r_miso <= 1'b0;
    end else if (resetn) begin
      r_miso <= 1'b0;
    end else begin
      r_miso <= r_cnt[3] ? r_rdata[~r_cnt[2:0]] : 1'b0;
    end
  end

  assign miso = ss ? 1'bz : r_miso;

  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    gpio_bank #(
      .PDATA_WIDTH (PDATA_WIDTH),
      .PADDR_WIDTH (PADDR_WIDTH)
    ) u_bank (
      .clk     (sclk),
      .rst     (resetn),
      .i_we    (w_wr_go && (sel_to_bank(w_wr_sel) == b)),
      .i_waddr (w_wr_addr),
      .i_wdata (w_wr_data),
      .i_raddr (w_rd_addr),
      .o_rdata (w_bank_rdata[b]),
      .io_pad  (pad[b*PDATA_WIDTH +: PDATA_WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_gpio_expander.sv
// ----------------------------------------------------------------------------
// tb_gpio_expander : directed SPI frames checked against a register-map model
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gpio_expander;

  logic        sclk   = 1'b0;
  logic        resetn = 1'b0;
  logic        ss     = 1'b1;
  logic        mosi   = 1'b0;
  wire         miso;
  wire  [15:0] pad;

  // Bench drives every pin the model says the DUT leaves floating.
  logic [15:0] ext_val = 16'h5A3C;
  logic [7:0]  m_out [2];
  logic [7:0]  m_dir [2];
  wire  [15:0] w_ext_en = ~{m_dir[1], m_dir[0]};

  int          n_chk  = 0;
  int          n_fail = 0;
  logic        chk_en = 1'b0;
  logic [15:0] last_rx;

  for (genvar i = 0; i < 16; i++) begin : g_ext
    assign pad[i] = w_ext_en[i] ? ext_val[i] : 1'bz;
  end

  always #5 sclk = ~sclk;

  gpio_expander dut (
    .sclk   (sclk),
    .resetn (resetn),
    .ss     (ss),
    .mosi   (mosi),
    .miso   (miso),
    .pad    (pad)
  );

  function automatic logic [15:0] exp_pad();
    logic [15:0] d;
    logic [15:0] o;
    d = {m_dir[1], m_dir[0]};
    o = {m_out[1], m_out[0]};
    return (o & d) | (ext_val & ~d);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] f);
    int         b;
    logic [7:0] lvl;
    if (f[14:13] == 2'b00 || f[14:13] == 2'b11) return 8'h00;
    b   = int'(f[14:13]) - 1;
    lvl = (m_out[b] & m_dir[b]) | (ext_val[8*b +: 8] & ~m_dir[b]);
    case (f[12:10])
      3'd0:    return m_out[b];
      3'd1:    return m_dir[b];
      3'd2:    return lvl;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_write(input logic [15:0] f);
    int b;
    if (!f[15] || f[14:13] == 2'b00 || f[14:13] == 2'b11) return;
    b = int'(f[14:13]) - 1;
    if (f[12:10] == 3'd0) m_out[b] = f[7:0];
    if (f[12:10] == 3'd1) m_dir[b] = f[7:0];
  endtask

  task automatic model_clear();
    m_out[0] = 8'h00; m_out[1] = 8'h00;
    m_dir[0] = 8'h00; m_dir[1] = 8'h00;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge sclk) begin
    if (chk_en) check("pad_track", pad, exp_pad());
  end

  task automatic send_frame(input logic [15:0] f, input int nbits, output logic [15:0] rx);
    rx = 16'h0000;
    @(negedge sclk);
    ss = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = f[15-i];
      @(posedge sclk);
      #1;
      rx = {rx[14:0], miso};
      if (i == 15) model_write(f);
      @(negedge sclk);
    end
    ss   = 1'b1;
    mosi = 1'b0;
  endtask

  task automatic xfer(input string name, input logic [15:0] f);
    logic [15:0] rx;
    logic [15:0] exp;
    exp = f[15] ? 16'h0000 : {8'h00, model_read(f)};
    send_frame(f, 16, rx);
    check(name, rx, exp);
    last_rx = rx;
  endtask

  task automatic do_reset();
    @(negedge sclk);
    resetn = 1'b1;
    @(posedge sclk);
    #1 model_clear();
    @(negedge sclk);
    resetn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rx;
    model_clear();
    repeat (2) @(negedge sclk);
    do_reset();
    chk_en = 1'b1;
    check("reset_pads_float", pad, 16'h5A3C);
    xfer("rd_b0_dir_reset", 16'h2400);
    check("rd_b0_dir_reset_lit", last_rx, 16'h0000);

    xfer("wr_b0_dir", 16'hA4FF);
    check("pad_b0_out_b1_z", pad, 16'h5A00);
    xfer("wr_b0_out", 16'hA0FF);
    xfer("wr_b1_dir", 16'hC4FF);
    xfer("wr_b1_out", 16'hC0FF);
    check("pad_all_high", pad, 16'hFFFF);

    xfer("rd_b0_out", 16'h2000);
    check("rd_b0_out_lit", last_rx, 16'h00FF);
    xfer("rd_b1_dir", 16'h4400);
    check("rd_b1_dir_lit", last_rx, 16'h00FF);

    xfer("wr_b1_dir_in", 16'hC400);
    ext_val[15:8] = 8'hA5;
    xfer("rd_b1_in", 16'h4800);
    check("rd_b1_in_lit", last_rx, 16'h00A5);
    xfer("rd_b0_in", 16'h2800);

    xfer("wr_sel11", 16'hE055);
    check("pad_sel11_nochange", pad, 16'hA5FF);
    xfer("rd_sel00", 16'h0000);
    check("rd_sel00_lit", last_rx, 16'h0000);
    xfer("rd_b0_addr5", 16'h3400);
    check("rd_b0_addr5_lit", last_rx, 16'h0000);

    send_frame(16'hA000, 10, rx);
    @(negedge sclk);
    check("pad_abort_nochange", pad, 16'hA5FF);
    xfer("rd_b0_out_after_abort", 16'h2000);
    check("rd_b0_out_after_abort_lit", last_rx, 16'h00FF);

    @(negedge sclk);
    ss = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b1;
      @(posedge sclk);
      @(negedge sclk);
    end
    resetn = 1'b1;
    @(posedge sclk);
    #1 model_clear();
    @(negedge sclk);
    resetn = 1'b0;
    ss     = 1'b1;
    mosi   = 1'b0;
    @(negedge sclk);
    check("pad_midframe_reset", pad, 16'hA53C);
    xfer("rd_b0_out_post_rst", 16'h2000);
    check("rd_b0_out_post_rst_lit", last_rx, 16'h0000);
    xfer("rd_b1_dir_post_rst", 16'h4400);
    check("rd_b1_dir_post_rst_lit", last_rx, 16'h0000);

    @(negedge sclk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpio_expander.md
GPIO_EXPANDER -- requirements
Module: gpio_expander

Interface
REQ-001 The parameters SHALL be as follows:
- BANK_NUM, default 2: number of 8-bit pad banks.
- DATA_WIDTH, default 16: SPI frame length in bits.
- PDATA_WIDTH, default 8: bank width and register data width.
- ADDR_WIDTH, default 7: frame header width below the R/W bit (bits 14:8).
- PADDR_WIDTH, default 3: register address width within a bank.

REQ-002 The ports SHALL be as follows:
- sclk, input, 1 bit: the only clock; SPI serial clock.
- resetn, input, 1 bit: reset, synchronous to sclk and active-high (the port keeps the codebase name).
- ss, input, 1 bit: slave select, active-low.
- mosi, input, 1 bit: serial data in, MSB first.
- miso, output, 1 bit: serial data out, MSB first; high-Z while ss=1.
- pad, inout, BANK_NUM*PDATA_WIDTH bits: GPIO pins; bank b occupies pad[8b+7:8b].

Function
REQ-003 Frames SHALL be 16 bits, MSB first, with fields:
- bit15 RW: 1 = write, 0 = read.
- bits14:13 SEL: 01 = bank0, 10 = bank1; 00 and 11 are invalid.
- bits12:10 ADDR.
- bits9:8 reserved, ignored.
- bits7:0 DATA.
REQ-004 SPI mode 0 SHALL be used: mosi is sampled on the sclk rising edge; miso changes only on the sclk falling edge.
REQ-005 A 4-bit bit counter SHALL increment on each rising edge while ss=0 and wrap to 0 after the 16th bit.
REQ-006 ss=1 SHALL asynchronously hold the bit counter and shift register at 0 and tri-state miso; a frame aborted mid-transfer SHALL leave all registers unchanged.
REQ-007 Each bank SHALL have the following registers:
- ADDR 0, OUT: 8 bits, read/write.
- ADDR 1, DIR: 8 bits, read/write; 1 = output.
- ADDR 2, IN: read-only, the current pad levels of the bank.
- ADDR 3-7: writes ignored, reads return 0x00.
REQ-008 A write frame SHALL commit DATA to the selected register on the 16th rising edge; the new value SHALL be visible at the pads immediately after that edge.
REQ-009 For a read frame, the read data SHALL be latched on the 8th rising edge, once RW, SEL and ADDR are known.
REQ-010 For a read frame, miso SHALL output 0 during frame bits 15..8, then data bits 7..0 on successive falling edges, starting with the falling edge after the 8th rising edge.
REQ-011 During write frames miso SHALL output 0.
REQ-012 An invalid SEL SHALL cause writes to be ignored and reads to return 0x00.
REQ-013 Each pad[i] SHALL be driven with OUT[i] when DIR[i]=1 and SHALL be high-Z otherwise.
REQ-014 IN SHALL reflect the resolved pad value, including an externally driven value, sampled at the 8th rising edge of a read frame.
REQ-015 A pad configured as output and driven externally to the same level SHALL read back that level.
REQ-016 Frames SHALL be back-to-back capable: deasserting ss for at least one bench clock between frames is sufficient.

Reset
REQ-017 resetn=1 sampled on a sclk rising edge SHALL clear OUT=0x00 and DIR=0x00 in all banks (all pads high-Z), clear the bit counter and shift register, and hold miso at 0 while ss=0.
REQ-018 A reset asserted mid-frame SHALL abort the frame with no register update.
REQ-019 The bench SHALL toggle sclk while resetn=1 for reset to take effect.

Structure
REQ-020 A shared package gpio_expander_pkg SHALL hold:
- the frame field bit positions;
- the SEL codes;
- the register addresses OUT, DIR and IN;
- the reset values;
- the widths DATA_WIDTH, PDATA_WIDTH and PADDR_WIDTH.
REQ-021 The design SHALL be split as follows:
- Sub-module gpio_bank, one instance per bank: OUT/DIR registers, IN read mux and tri-state pad driver.
- Top level: SPI shift/decode logic.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then write bank0 DIR=0xFF -> pad[7:0]=0x00 and pad[15:8]=Z.
- Write bank0 OUT=0xFF, then bank1 DIR=0xFF and OUT=0xFF -> pad=0xFFFF.
- Read bank0 OUT (frame 0x2000) -> captured miso word 0x00FF; read bank1 DIR (frame 0x4400) -> 0x00FF.
- Bank1 DIR=0x00, external drive pad[15:8]=0xA5, read bank1 IN (frame 0x4800) -> 0x00A5.
- Write with SEL=11 and DATA=0x55 -> no pad change; read with SEL=00 -> 0x0000.
- Deassert ss after 10 bits of a write of OUT=0x00 -> OUT unchanged; assert resetn mid-frame -> OUT=0x00, DIR=0x00, pads Z.
